simon32_64_key_expand: RTL and testbench
========================================

SIMON32_64_KEY_EXPAND -- requirements
Module: simon32_64_key_expand

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 32, number of 16-bit round keys emitted per key.
REQ-002 SHALL have parameter WORD, default 16, Simon word width n.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key  input  64  master key; key[15:0]=k0, key[31:16]=k1, key[47:32]=k2, key[63:48]=k3.
REQ-006 SHALL have port key_valid  input  1  key holds a new master key.
REQ-007 SHALL have port key_ready  output  1  block can accept a master key.
REQ-008 SHALL have port rk  output  16  current round key k[i].
REQ-009 SHALL have port rk_valid  output  1  rk is valid.
REQ-010 SHALL have port rk_ready  input  1  downstream round core consumes rk this cycle.
REQ-011 SHALL have port rk_index  output  5  round number i of rk.
REQ-012 SHALL have port rk_last  output  1  high when rk_valid and rk_index==NUM_ROUNDS-1.

Function
REQ-013 SHALL implement two states: IDLE (key_ready=1, rk_valid=0) and EMIT (key_ready=0, rk_valid=1).
REQ-014 IDLE->EMIT SHALL occur on the cycle key_valid&&key_ready; rk_valid rises the next cycle with rk=k0, rk_index=0 (latency 1 cycle).
REQ-015 In EMIT, a handshake is rk_valid&&rk_ready; each handshake advances rk_index by 1 and presents k[i+1] on the following cycle.
REQ-016 When rk_valid&&!rk_ready, rk, rk_index and rk_last SHALL hold stable.
REQ-017 Handshake with rk_last=1 SHALL return to IDLE; key_ready=1 the next cycle; one idle cycle minimum between keys.
REQ-018 key_valid while in EMIT SHALL be ignored; no key is latched and emission is unaffected.
REQ-019 Expansion: k[i+4] = ~k[i] ^ z0[i] ^ 3 ^ t ^ (t ror 1), with t = (k[i+3] ror 3) ^ k[i+1]; i.e. c=16'hFFFC XOR z0[i] in bit 0.
REQ-020 z0 SHALL be the 62-bit sequence 11111010001001010110000111001101111101000100101011000011100110, z0[0] the leftmost bit; only z0[0..27] are used.
REQ-021 Key state SHALL be a 4-word window {k[i+3],k[i+2],k[i+1],k[i]}; rk = lowest word; each handshake shifts in k[i+4].
REQ-022 rk_index SHALL not wrap inside a key; it resets to 0 on each accepted key.
REQ-023 All arithmetic SHALL be modulo 2^16; rotations are within 16 bits.

Reset
REQ-024 reset=1 SHALL force IDLE, key_ready=1 after the reset cycle ends, rk_valid=0, rk=0, rk_index=0, rk_last=0, key window=0.
REQ-025 reset asserted mid-EMIT SHALL abort emission immediately; no further rk_valid until a new key is accepted.
REQ-026 reset SHALL take priority over a simultaneous key_valid or rk_ready.

Structure
REQ-027 Package simon_pkg SHALL hold Z0 (62-bit constant), C_CONST=16'hFFFC, NUM_ROUNDS, and the state enum {IDLE, EMIT}.
REQ-028 Combinational sub-module simon32_64_key_step SHALL compute k[i+4] from k[i], k[i+1], k[i+3], and z-bit; reusable by the round core bench model.
REQ-029 Outputs SHALL be driven from flops; no combinational path key->rk or rk_ready->key_ready.

Verification
REQ-030 Key 64'h1918_1110_0908_0100, rk_ready=1 -> rk sequence begins 0100, 0908, 1110, 1918 at indices 0..3, 32 words total, rk_last only on index 31.
REQ-031 Same key, all 32 rk compared against the software key schedule; feeding them to simon32_64 with plaintext 32'h6565_6877 -> ciphertext 32'hc69b_e9bb.
REQ-032 Random rk_ready (50% duty) -> identical 32-word sequence; rk/rk_index stable on every stalled cycle.
REQ-033 reset pulsed at rk_index=10 -> rk_valid=0 next cycle, key_ready=1, subsequent key 64'h0 emits rk=0000 first.
REQ-034 key_valid held high with alternating keys during EMIT -> second key accepted only after rk_last handshake plus one cycle; no corruption of first sequence.
REQ-035 Back-to-back keys with rk_ready=1 -> exactly 33-cycle period per key (1 accept + 32 emit).

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared constants and types for the Simon32/64 key schedule.
//   Z0         - 62-bit round-constant sequence, z0[0] is the MSB (bit 61)
//   C_CONST    - 16'hFFFC, i.e. ~3 folded into the schedule constant
//   NUM_ROUNDS - round keys per master key
//   state_e    - key-expander FSM states
package simon_pkg;
    localparam logic [61:0] Z0         = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [15:0] C_CONST    = 16'hFFFC;
    localparam int          NUM_ROUNDS = 32;
    typedef enum logic { IDLE, EMIT } state_e;
endpackage

// File: rtl/simon32_64_key_step.sv
// simon32_64_key_step: one Simon key-schedule step (m=4), purely combinational.
//   k0_i, k1_i, k3_i - window words k[i], k[i+1], k[i+3]
//   z_i              - round-constant bit z0[i]
//   k4_o             - next key word k[i+4]
module simon32_64_key_step #(
    parameter int WORD = 16
) (
    input  logic [WORD-1:0] k0_i,
    input  logic [WORD-1:0] k1_i,
    input  logic [WORD-1:0] k3_i,
    input  logic            z_i,
    output logic [WORD-1:0] k4_o
);
    logic [WORD-1:0] t;
    assign t    = {k3_i[2:0], k3_i[WORD-1:3]} ^ k1_i;
    // ~k0 ^ 3 is the same as k0 ^ 16'hFFFC for the default width
    assign k4_o = ~k0_i ^ WORD'(3) ^ WORD'(z_i) ^ t ^ {t[0], t[WORD-1:1]};
endmodule

// File: rtl/simon32_64_key_expand.sv
// simon32_64_key_expand: streams NUM_ROUNDS Simon32/64 round keys per master key.
//   clk, reset          - clock, synchronous active-high reset
//   key, key_valid      - master key input, accepted in IDLE (key_ready=1)
//   key_ready           - high while idle
//   rk, rk_index        - current round key and its index
//   rk_valid, rk_ready  - round-key handshake; rk_last flags the final key
module simon32_64_key_expand
    import simon_pkg::*;
#(
    parameter int NUM_ROUNDS = simon_pkg::NUM_ROUNDS,
    parameter int WORD       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4*WORD-1:0] key,
    input  logic            key_valid,
    output logic            key_ready,
    output logic [WORD-1:0] rk,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [4:0]      rk_index,
    output logic            rk_last
);
    localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

    state_e            state_q;
    logic [4*WORD-1:0] win_q;
    logic [4:0]        idx_q;
    logic              key_ready_q, rk_valid_q, rk_last_q;
    logic [WORD-1:0]   k_next;
    logic [5:0]        z_sel;

    // z0[0] sits at bit 61 of Z0
    assign z_sel = 6'd61 - {1'b0, idx_q};

    simon32_64_key_step #(.WORD(WORD)) u_step (
        .k0_i (win_q[WORD-1:0]),
        .k1_i (win_q[2*WORD-1:WORD]),
        .k3_i (win_q[4*WORD-1:3*WORD]),
        .z_i  (Z0[z_sel]),
        .k4_o (k_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            idx_q       <= '0;
            win_q       <= '0;
        end else if (state_q == IDLE) begin
            if (key_valid) begin
                state_q     <= EMIT;
                key_ready_q <= 1'b0;
                rk_valid_q  <= 1'b1;
                rk_last_q   <= (LAST == 5'd0);
                idx_q       <= '0;
                win_q       <= key;
            end
        end else if (rk_ready) begin
            if (rk_last_q) begin
                state_q     <= IDLE;
                key_ready_q <= 1'b1;
                rk_valid_q  <= 1'b0;
                rk_last_q   <= 1'b0;
            end else begin
                win_q     <= {k_next, win_q[4*WORD-1:WORD]};
                idx_q     <= idx_q + 5'd1;
                rk_last_q <= (idx_q + 5'd1 == LAST);
            end
        end
    end

    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_last_q;
    assign rk_index  = idx_q;
    assign rk        = win_q[WORD-1:0];
endmodule

// File: tb/tb_simon32_64_key_expand.sv
// tb_simon32_64_key_expand: directed self-checking bench for the Simon32/64 key expander.
module tb_simon32_64_key_expand;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] key;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] rk;
    logic        rk_valid;
    logic        rk_ready;
    logic [4:0]  rk_index;
    logic        rk_last;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_B = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] KEY_C = 64'hdead_beef_5a5a_c3c3;
    localparam logic [61:0] Z0_TB = 62'b11111010001001010110000111001101111101000100101011000011100110;

    logic [15:0] exp_k [32];
    logic [15:0] got_k [32];

    simon32_64_key_expand dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk        (rk),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_index  (rk_index),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] x, input int r);
        return (x >> r) | (x << (16 - r));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] x, input int r);
        return (x << r) | (x >> (16 - r));
    endfunction

    task automatic build(input logic [63:0] k);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) exp_k[i] = k[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            t = ror16(exp_k[i+3], 3) ^ exp_k[i+1];
            exp_k[i+4] = ~exp_k[i] ^ t ^ ror16(t, 1) ^ 16'd3 ^ {15'd0, Z0_TB[61-i]};
        end
    endtask

    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x, y, tmp;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ got_k[i];
            y = tmp;
        end
        return {x, y};
    endfunction

    task automatic accept(input logic [63:0] k);
        key = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic run_full(input string tag);
        rk_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check({tag, "_rk"}, 64'(rk), 64'(exp_k[i]));
            check({tag, "_idx"}, 64'(rk_index), 64'(i));
            check({tag, "_last"}, 64'(rk_last), 64'(i == 31));
            check({tag, "_valid"}, 64'(rk_valid), 64'd1);
            got_k[i] = rk;
            step();
        end
        check({tag, "_done_valid"}, 64'(rk_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(key_ready), 64'd1);
    endtask

    initial begin
        int n;
        logic [63:0] kx;
        reset = 1'b1;
        key = '0;
        key_valid = 1'b0;
        rk_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_rk_valid", 64'(rk_valid), 64'd0);
        check("rst_rk", 64'(rk), 64'd0);
        check("rst_idx", 64'(rk_index), 64'd0);
        check("rst_last", 64'(rk_last), 64'd0);

        // Reference key: first four words are the key itself, then encrypt vector
        build(KEY_A);
        accept(KEY_A);
        check("a_key_ready_busy", 64'(key_ready), 64'd0);
        check("a_rk0", 64'(rk), 64'h0100);
        run_full("a");
        check("a_rk1", 64'(got_k[1]), 64'h0908);
        check("a_rk2", 64'(got_k[2]), 64'h1110);
        check("a_rk3", 64'(got_k[3]), 64'h1918);
        check("a_cipher", 64'(encrypt(32'h6565_6877)), 64'h0000_0000_c69b_e9bb);

        // Random back-pressure: stalled cycles must hold rk/rk_index/rk_last
        step();
        build(KEY_B);
        accept(KEY_B);
        n = 0;
        for (int c = 0; c < 1000 && n < 32; c++) begin
            rk_ready = 1'($urandom_range(0, 1));
            check("stall_rk", 64'(rk), 64'(exp_k[n]));
            check("stall_idx", 64'(rk_index), 64'(n));
            check("stall_last", 64'(rk_last), 64'(n == 31));
            check("stall_valid", 64'(rk_valid), 64'd1);
            if (rk_ready) n++;
            step();
        end
        check("stall_count", 64'(n), 64'd32);
        check("stall_done", 64'(rk_valid), 64'd0);

        // Reset in the middle of emission
        rk_ready = 1'b1;
        accept(KEY_A);
        repeat (10) step();
        check("mid_idx", 64'(rk_index), 64'd10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 64'(rk_valid), 64'd0);
        check("mid_rst_ready", 64'(key_ready), 64'd1);
        check("mid_rst_rk", 64'(rk), 64'd0);
        check("mid_rst_idx", 64'(rk_index), 64'd0);
        repeat (3) step();
        check("mid_quiet", 64'(rk_valid), 64'd0);
        build(64'h0);
        accept(64'h0);
        check("zero_rk0", 64'(rk), 64'h0000);
        run_full("zero");

        // key_valid held with changing keys while emitting must be ignored
        build(KEY_A);
        accept(KEY_A);
        key_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("hold_rk", 64'(rk), 64'(exp_k[i]));
            check("hold_idx", 64'(rk_index), 64'(i));
            key = (i % 2 == 1) ? KEY_B : KEY_C;
            step();
        end
        check("hold_idle", 64'(key_ready), 64'd1);
        kx = key;
        step();
        key_valid = 1'b0;
        build(kx);
        check("hold_next_valid", 64'(rk_valid), 64'd1);
        check("hold_next_rk0", 64'(rk), 64'(kx[15:0]));
        run_full("hold_next");

        // Back-to-back keys: one accept cycle + 32 emit cycles
        key = KEY_A;
        key_valid = 1'b1;
        rk_ready = 1'b1;
        step();
        check("b2b_first", 64'(rk), 64'h0100);
        n = 0;
        do begin
            step();
            n++;
        end while (!(rk_valid && rk_index == 5'd0) && n < 100);
        check("b2b_period", 64'(n), 64'd33);
        check("b2b_second", 64'(rk), 64'h0100);
        key_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
